// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding, playlist
// entry layout and the reset-time playlist contents.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam int NUM_ENTRIES = 8;
  localparam int IDX_W       = 3;
  localparam int ENTRY_W     = 8;
  localparam int SPEED_BIT   = 7;
  localparam int PAT_LSB     = 4;
  localparam int PAT_W       = 3;
  localparam int DWELL_LSB   = 0;
  localparam int DWELL_W     = 4;

  localparam logic [PAT_W-1:0]   PAT_ALL_OFF = 3'b111;
  localparam logic [DWELL_W-1:0] RESET_DWELL = 4'd5;

  function automatic logic [PAT_W-1:0] entry_pat(input logic [ENTRY_W-1:0] e);
    return e[PAT_LSB +: PAT_W];
  endfunction

  function automatic logic [DWELL_W-1:0] entry_dwell(input logic [ENTRY_W-1:0] e);
    return e[DWELL_LSB +: DWELL_W];
  endfunction

  function automatic logic entry_speed(input logic [ENTRY_W-1:0] e);
    return e[SPEED_BIT];
  endfunction

  // Entries 0..6 show pattern i for 5 ticks; entry 7 is the end-of-list marker.
  function automatic logic [ENTRY_W-1:0] reset_entry(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_ENTRIES - 1))
      return {1'b0, PAT_ALL_OFF, DWELL_W'(0)};
    return {1'b0, i, RESET_DWELL};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-level counter; emits a single-cycle pulse
// when a press has been stable for DEB_CYCLES cycles. Releases are silent.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  // Fires in the cycle where the accepted level is about to flip low->high.
  assign pulse = sync2_reg & ~stable_reg & (cnt_reg == CNT_LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a pattern generator through an 8-entry playlist with per-entry dwell,
// pause and next-entry buttons, and a level start enable.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV   = 5000000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic       ena,
  output logic [2:0] pat_sel,
  output logic       speed_sel,
  output logic       pause,
  output logic [2:0] cur_idx,
  output logic       step
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [ENTRY_W-1:0]     mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] is_marker;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [PAT_W-1:0]   pat_reg;
  logic               speed_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [TW-1:0]      tick_cnt_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;
  logic               step_reg;
  logic               ena_reg;
  logic               pause_reg;

  logic               next_pulse;
  logic               pause_pulse;
  logic               load;
  logic [IDX_W-1:0]   load_idx;
  logic [IDX_W-1:0]   adv_idx_raw;
  logic [IDX_W-1:0]   adv_idx;
  logic [ENTRY_W-1:0] load_entry;
  logic               tick_done;
  logic               dwell_done;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .pulse (next_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_pause),
    .pulse (pause_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        mem[i] <= reset_entry(IDX_W'(i));
    end else if (cfg_we) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_marker
      assign is_marker[gi] = (entry_dwell(mem[gi]) == '0);
    end
  endgenerate

  // A marker always redirects to entry 0, so one lookahead check suffices.
  assign adv_idx_raw = idx_reg + IDX_W'(1);
  assign adv_idx     = is_marker[adv_idx_raw] ? '0 : adv_idx_raw;
  assign tick_done   = (tick_cnt_reg == TICK_LAST);
  assign dwell_done  = tick_done && (dwell_cnt_reg == dwell_reg - DWELL_W'(1));
  assign load_entry  = mem[load_idx];

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_idx   = adv_idx;
    case (state_reg)
      ST_IDLE: begin
        if (start && !is_marker[0]) begin
          state_next = ST_RUN;
          load       = 1'b1;
          load_idx   = '0;
        end
      end
      ST_RUN: begin
        if (!start) begin
          state_next = ST_IDLE;
        end else begin
          load = next_pulse | dwell_done;
          if (pause_pulse)
            state_next = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!start) begin
          state_next = ST_IDLE;
        end else begin
          load = next_pulse;
          if (pause_pulse)
            state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      pat_reg       <= PAT_ALL_OFF;
      speed_reg     <= 1'b0;
      dwell_reg     <= '0;
      tick_cnt_reg  <= '0;
      dwell_cnt_reg <= '0;
      step_reg      <= 1'b0;
      ena_reg       <= 1'b0;
      pause_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= load;
      ena_reg   <= (state_next != ST_IDLE);
      pause_reg <= (state_next == ST_PAUSED);
      if (state_next == ST_IDLE) begin
        idx_reg       <= '0;
        pat_reg       <= PAT_ALL_OFF;
        speed_reg     <= 1'b0;
        tick_cnt_reg  <= '0;
        dwell_cnt_reg <= '0;
      end else if (load) begin
        idx_reg       <= load_idx;
        pat_reg       <= entry_pat(load_entry);
        speed_reg     <= entry_speed(load_entry);
        dwell_reg     <= entry_dwell(load_entry);
        tick_cnt_reg  <= '0;
        dwell_cnt_reg <= '0;
      end else if (state_reg == ST_RUN) begin
        if (tick_done) begin
          tick_cnt_reg  <= '0;
          dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
        end else begin
          tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
      end
    end
  end

  assign ena       = ena_reg;
  assign pat_sel   = pat_reg;
  assign speed_sel = speed_reg;
  assign pause     = pause_reg;
  assign cur_idx   = idx_reg;
  assign step      = step_reg;

endmodule
